// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencer for the fetch stage.
//
// Owns the PC register and one shared 30-bit word adder that is time-
// multiplexed between the pc+4 step and the branch-offset add. Requests
// arrive on a valid/ready handshake. Every PC write gives a one-cycle
// pc_upd pulse and bumps upd_cnt.
//
// Optional build macro: PC_SEQ_BR_FAST_EN. It adds a dedicated second adder
// so that taken branches complete from ADD1 in one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   adv_valid  request to advance the PC
//   adv_ready  request can be accepted this cycle (IDLE and not in reset)
//   kind       00 seq, 01 branch, 10 jump, 11 reserved (treated as seq)
//   br_taken   branch outcome, sampled at accept
//   imm        signed 16-bit word offset, sampled at accept
//   jtarget    26-bit jump word index, sampled at accept
//   pc         current PC, bits [1:0] always 0
//   pc_upd     one-cycle pulse in the cycle after each PC write
//   upd_cnt    PC writes since reset, wraps silently
//
// state | meaning
// IDLE  | waiting for a request; adv_ready high
// ADD1  | adder forms pc+4; seq/jump/not-taken (and fast taken) finish here
// ADD2  | adder forms seq + sext(imm) for a taken branch

module full_adder_30 (
    input  logic [29:0] a,
    input  logic [29:0] b,
    input  logic        cin,
    output logic [29:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {30'd0, cin};
endmodule

module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_valid,
    output logic             adv_ready,
    input  logic [1:0]       kind,
    input  logic             br_taken,
    input  logic [15:0]      imm,
    input  logic [25:0]      jtarget,
    output logic [31:0]      pc,
    output logic             pc_upd,
    output logic [CNT_W-1:0] upd_cnt
);
    typedef enum logic [1:0] {IDLE, ADD1, ADD2} state_t;

    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

    state_t             state_q, state_d;
    logic [29:0]        pc_q, pc_d;
    logic [1:0]         kind_q, kind_d;
    logic               taken_q, taken_d;
    logic [15:0]        imm_q, imm_d;
    logic [25:0]        jt_q, jt_d;
    logic               pc_upd_q, pc_upd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [29:0]        imm_sext;
    logic [29:0]        add_a, add_b, add_sum;
    logic               add_c;
    logic               add_cout_unused;

    assign imm_sext = {{14{imm_q[15]}}, imm_q};

`ifdef PC_SEQ_BR_FAST_EN
    // Dedicated branch adder chained off the shared pc+4 result.
    logic [29:0] fast_sum;
    logic        fast_cout_unused;

    full_adder_30 u_br_adder (
        .a    (add_sum),
        .b    (imm_sext),
        .cin  (1'b0),
        .sum  (fast_sum),
        .cout (fast_cout_unused)
    );

    always_comb begin
        add_a = pc_q;
        add_b = 30'd0;
        add_c = 1'b1;
    end
`else
    logic [29:0] seq_q, seq_d;

    // Shared adder: pc+1 word in ADD1, seq + offset in ADD2.
    always_comb begin
        add_a = pc_q;
        add_b = 30'd0;
        add_c = 1'b1;
        if (state_q == ADD2) begin
            add_a = seq_q;
            add_b = imm_sext;
            add_c = 1'b0;
        end
    end
`endif

    full_adder_30 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_c),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kind_d   = kind_q;
        taken_d  = taken_q;
        imm_d    = imm_q;
        jt_d     = jt_q;
        pc_upd_d = 1'b0;
        cnt_d    = cnt_q;
`ifndef PC_SEQ_BR_FAST_EN
        seq_d    = seq_q;
`endif
        case (state_q)
            IDLE: begin
                if (adv_valid) begin
                    kind_d  = kind;
                    taken_d = br_taken;
                    imm_d   = imm;
                    jt_d    = jtarget;
                    state_d = ADD1;
                end
            end
            ADD1: begin
                pc_upd_d = 1'b1;
                state_d  = IDLE;
                if (kind_q == 2'b10) begin
                    // Jump keeps the top 4 byte-address bits of pc+4.
                    pc_d = {add_sum[29:26], jt_q};
                end else if (kind_q == 2'b01 && taken_q) begin
`ifdef PC_SEQ_BR_FAST_EN
                    pc_d = fast_sum;
`else
                    seq_d    = add_sum;
                    pc_upd_d = 1'b0;
                    state_d  = ADD2;
`endif
                end else begin
                    pc_d = add_sum;
                end
            end
            ADD2: begin
                pc_d     = add_sum;
                pc_upd_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (pc_upd_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_WORD;
            kind_q   <= 2'b00;
            taken_q  <= 1'b0;
            imm_q    <= 16'd0;
            jt_q     <= 26'd0;
            pc_upd_q <= 1'b0;
            cnt_q    <= '0;
`ifndef PC_SEQ_BR_FAST_EN
            seq_q    <= 30'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            kind_q   <= kind_d;
            taken_q  <= taken_d;
            imm_q    <= imm_d;
            jt_q     <= jt_d;
            pc_upd_q <= pc_upd_d;
            cnt_q    <= cnt_d;
`ifndef PC_SEQ_BR_FAST_EN
            seq_q    <= seq_d;
`endif
        end
    end

    assign adv_ready = (state_q == IDLE) && !rst;
    assign pc        = {pc_q, 2'b00};
    assign pc_upd    = pc_upd_q;
    assign upd_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        adv_valid, adv_valid_w;
    logic [1:0]  kind;
    logic        br_taken;
    logic [15:0] imm;
    logic [25:0] jtarget;

    logic        adv_ready, adv_ready_w;
    logic [31:0] pc, pc_w;
    logic        pc_upd, pc_upd_w;
    logic [15:0] upd_cnt, upd_cnt_w;

`ifdef PC_SEQ_BR_FAST_EN
    localparam int TAKEN_LAT = 1;
`else
    localparam int TAKEN_LAT = 2;
`endif

    pc_seq_ctrl dut (
        .clk(clk), .rst(rst), .adv_valid(adv_valid), .adv_ready(adv_ready),
        .kind(kind), .br_taken(br_taken), .imm(imm), .jtarget(jtarget),
        .pc(pc), .pc_upd(pc_upd), .upd_cnt(upd_cnt)
    );

    pc_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst), .adv_valid(adv_valid_w), .adv_ready(adv_ready_w),
        .kind(kind), .br_taken(br_taken), .imm(imm), .jtarget(jtarget),
        .pc(pc_w), .pc_upd(pc_upd_w), .upd_cnt(upd_cnt_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc_q[$];
    int          exp_lat_q[$];
    logic [31:0] mpc, mpc_w;
    logic [15:0] exp_cnt, exp_cnt_w;

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] k,
                                               input logic t, input logic [15:0] im,
                                               input logic [25:0] jt);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (k == 2'b10)          return {seq[31:28], jt, 2'b00};
        if (k == 2'b01 && t)     return seq + {{14{im[15]}}, im, 2'b00};
        return seq;
    endfunction

    // Pops the scoreboard when the selected DUT pulses pc_upd. Entered at the
    // negedge following the accept edge.
    task automatic wait_upd(input bit w, input string nm);
        logic [31:0] e;
        int          lat;
        bit          seen;
        seen = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            if ((w ? pc_upd_w : pc_upd) === 1'b1) begin
                seen = 1;
                checks++;
                if (exp_pc_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s: unexpected pc_upd, scoreboard empty", nm);
                end else begin
                    e   = exp_pc_q.pop_front();
                    lat = exp_lat_q.pop_front();
                    if (w) begin mpc_w = e; exp_cnt_w++; end
                    else   begin mpc = e;   exp_cnt++;   end
                    if (c != lat + 1) begin
                        errors++;
                        $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, c - 1, lat);
                    end
                    checks++;
                    if ((w ? pc_w : pc) !== e) begin
                        errors++;
                        $display("FAIL %s_pc: got %h, expected %h", nm, w ? pc_w : pc, e);
                    end
                    checks++;
                    if ((w ? upd_cnt_w : upd_cnt) !== (w ? exp_cnt_w : exp_cnt)) begin
                        errors++;
                        $display("FAIL %s_cnt: got %0d, expected %0d", nm,
                                 w ? upd_cnt_w : upd_cnt, w ? exp_cnt_w : exp_cnt);
                    end
                    checks++;
                    if ((w ? adv_ready_w : adv_ready) !== 1'b1) begin
                        errors++;
                        $display("FAIL %s_ready_after: got %b, expected 1", nm, w ? adv_ready_w : adv_ready);
                    end
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no pc_upd within 8 cycles, expected one", nm);
        end
    endtask

    task automatic do_req(input bit w, input logic [1:0] k, input logic t,
                          input logic [15:0] im, input logic [25:0] jt, input string nm);
        logic [31:0] nxt;
        int          lat;
        int          i;
        nxt = model_next(w ? mpc_w : mpc, k, t, im, jt);
        lat = (k == 2'b01 && t) ? TAKEN_LAT : 1;
        i = 0;
        while ((w ? adv_ready_w : adv_ready) !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (i >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_wait: adv_ready stayed %b, expected 1", nm, w ? adv_ready_w : adv_ready);
        end
        kind = k; br_taken = t; imm = im; jtarget = jt;
        if (w) adv_valid_w = 1'b1; else adv_valid = 1'b1;
        exp_pc_q.push_back(nxt);
        exp_lat_q.push_back(lat);
        @(posedge clk);
        #1;
        adv_valid = 1'b0; adv_valid_w = 1'b0;
        // Held copies must be used, so scramble the live inputs.
        kind = 2'($urandom); br_taken = 1'($urandom); imm = 16'($urandom); jtarget = 26'($urandom);
        @(negedge clk);
        checks++;
        if ((w ? adv_ready_w : adv_ready) !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: adv_ready got %b, expected 0", nm, w ? adv_ready_w : adv_ready);
        end
        wait_upd(w, nm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adv_valid = 1'b0; adv_valid_w = 1'b0;
        kind = 2'b00; br_taken = 1'b0; imm = 16'd0; jtarget = 26'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (adv_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_in_rst: got %b, expected 0", adv_ready);
        end
        rst = 1'b0;
        #1;
        mpc = 32'h0040_0000; mpc_w = 32'hFFFF_FFFC; exp_cnt = 0; exp_cnt_w = 0;
        checks++;
        if (pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc: got %h, expected %h", pc, 32'h0040_0000); end
        checks++;
        if (upd_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d, expected 0", upd_cnt); end
        checks++;
        if (pc_upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b, expected 0", pc_upd); end
        checks++;
        if (adv_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", adv_ready); end
        checks++;
        if (pc_w !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_w: got %h, expected %h", pc_w, 32'hFFFF_FFFC); end
    endtask

    task automatic test_seq();
        do_req(0, 2'b00, 1'b0, 16'h0000, 26'd0, "seq");
    endtask

    task automatic test_branch();
        do_req(0, 2'b01, 1'b1, 16'hFFFF, 26'd0, "br_taken_neg");
        do_req(0, 2'b01, 1'b0, 16'h1234, 26'd0, "br_not_taken");
    endtask

    task automatic test_jump();
        do_req(0, 2'b10, 1'b1, 16'h7777, 26'h0000010, "jump");
        do_req(0, 2'b11, 1'b1, 16'h0040, 26'h3FFFFFF, "reserved");
        do_req(0, 2'b01, 1'b1, 16'h0010, 26'd0, "br_taken_pos");
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        kind = 2'b00; br_taken = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            exp_pc_q.push_back(mpc + 32'(4 * n));
            exp_lat_q.push_back(1);
        end
        adv_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (pc_upd === 1'b1) begin
                pulses++;
                checks++;
                if (exp_pc_q.size() == 0) begin
                    errors++;
                    $display("FAIL hold_extra_update: pc %h with scoreboard empty", pc);
                end else begin
                    mpc = exp_pc_q.pop_front();
                    void'(exp_lat_q.pop_front());
                    exp_cnt++;
                    if (pc !== mpc) begin
                        errors++;
                        $display("FAIL hold_pc: got %h, expected %h", pc, mpc);
                    end
                end
            end
            if (k == 5) adv_valid = 1'b0;
        end
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL hold_pulses: got %0d, expected 3", pulses); end
        checks++;
        if (upd_cnt !== exp_cnt) begin errors++; $display("FAIL hold_cnt: got %0d, expected %0d", upd_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        do_req(1, 2'b00, 1'b0, 16'h0000, 26'd0, "wrap_seq");
        do_req(1, 2'b01, 1'b1, 16'hFFFC, 26'd0, "wrap_neg_branch");
    endtask

    task automatic test_reset_mid();
        int i;
        i = 0;
        while (adv_ready !== 1'b1 && i < 20) begin @(negedge clk); i++; end
        kind = 2'b01; br_taken = 1'b1; imm = 16'h0020;
        adv_valid = 1'b1;
        @(posedge clk);
        #1;
        adv_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_pc_q.delete(); exp_lat_q.delete();
        mpc = 32'h0040_0000; exp_cnt = 0;
        checks++;
        if (pc !== 32'h0040_0000) begin errors++; $display("FAIL rstmid_pc: got %h, expected %h", pc, 32'h0040_0000); end
        checks++;
        if (upd_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d, expected 0", upd_cnt); end
        checks++;
        if (pc_upd !== 1'b0) begin errors++; $display("FAIL rstmid_upd: got %b, expected 0", pc_upd); end
        checks++;
        if (adv_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %b, expected 0", adv_ready); end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (pc_upd !== 1'b0 || pc !== 32'h0040_0000 || adv_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_idle: got upd=%b pc=%h ready=%b, expected 0/00400000/1", pc_upd, pc, adv_ready);
            end
        end
        do_req(0, 2'b00, 1'b0, 16'h0000, 26'd0, "seq_after_rst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Program-counter sequencer for the processor's fetch stage.
- Owns the PC register and one shared instance of the team's 30-bit word adder (`full_adder_30`, operating on PC[31:2]).
- Time-multiplexes that adder to compute sequential, branch-taken and jump next-PC values under a valid/ready handshake.
- Bumps a commit counter on every PC update.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset; bits [1:0] are forced to 0 internally.
- CNT_W, 16, width of the PC-update counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- adv_valid  in  1  request to advance the PC.
- adv_ready  out  1  controller can accept a request this cycle.
- kind  in  2  00 sequential, 01 branch, 10 jump, 11 reserved (treated as sequential).
- br_taken  in  1  branch outcome; sampled with the request.
- imm  in  16  signed word offset for branches; sampled with the request.
- jtarget  in  26  jump word index; sampled with the request.
- pc  out  32  current PC register.
- pc_upd  out  1  one-cycle pulse in the cycle after the PC register changes.
- upd_cnt  out  CNT_W  number of PC updates since reset.

Behaviour:
- Reset (rst high at an edge):
  - pc = {RESET_PC[31:2],2'b00}; upd_cnt = 0; pc_upd = 0; state = IDLE.
  - adv_ready = 0 while rst is high.
- States: IDLE, ADD1, ADD2.
  - adv_ready = 1 only in IDLE with rst low.
- IDLE:
  - A request is accepted at an edge when adv_valid & adv_ready.
  - On accept, latch kind, br_taken, imm, jtarget into holding registers and go to ADD1.
  - adv_valid while adv_ready = 0 is ignored; the requester must hold it.
- ADD1:
  - Adder operands: a = pc[31:2], b = 0, c = 1. Result is seq = pc+4.
  - Sequential, reserved kind, or branch not taken: pc <= {seq,2'b00} → IDLE.
  - Jump: pc <= {seq[31:28], jtarget, 2'b00} → IDLE.
  - Branch taken: seq_q <= seq → ADD2.
- ADD2:
  - Adder operands: a = seq_q[29:0], b = {{14{imm[15]}}, imm}, c = 0.
  - pc <= {sum,2'b00} → IDLE.
- Latency from accept edge to pc update:
  - sequential, not-taken, jump: 1 cycle.
  - taken branch: 2 cycles.
  - Back-to-back sequential requests therefore complete one per 2 cycles.
- pc_upd:
  - High for exactly the cycle following each edge at which pc is written.
  - upd_cnt increments at that same edge.
- Arithmetic:
  - All adds are modulo 2^30 words; adder carry-out is discarded.
  - 0xFFFFFFFC+4 = 0x00000000. Negative offsets wrap below 0.
- pc[1:0] always reads 0.
- Reset mid-operation:
  - The in-flight request is abandoned and the pc reset value wins.
  - No pc_upd pulse; upd_cnt = 0.
- upd_cnt wraps from all-ones to 0 silently.
- Held inputs are not re-sampled after accept; changes during ADD1/ADD2 have no effect.

Optional Feature:
- Macro PC_SEQ_BR_FAST_EN.
- When defined:
  - A second, dedicated 30-bit adder computes (pc[31:2]+1) + sext(imm) in ADD1.
  - Taken branches complete from ADD1 in 1 cycle; ADD2 is unreachable and optimized away.
- When undefined: the single shared adder and 2-cycle taken-branch latency described above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset release with RESET_PC default → pc=0x00400000, upd_cnt=0, pc_upd=0, adv_ready=1 on the first cycle after reset.
- Sequential request accepted at edge N:
  - adv_ready=0 in the cycle after edge N.
  - pc=0x00400004 after edge N+1, with a one-cycle pc_upd pulse.
  - upd_cnt=1; adv_ready=1.
- Branch from pc=0x00400004:
  - Taken with imm=0xFFFF → pc=0x00400004 two cycles after accept (pc+4-4), adv_ready low for 2 cycles.
  - Not taken → pc=0x00400008 after 1 cycle.
  - With PC_SEQ_BR_FAST_EN, the taken case completes in 1 cycle.
- Jump at pc=0x00400008 with jtarget=26'h0000010 → pc=0x00000040.
- Wrap and hold:
  - RESET_PC=32'hFFFFFFFC, sequential request → pc=0x00000000.
  - adv_valid held during busy cycles → exactly one update per accepted request.
- rst asserted during ADD2 of a taken branch → next cycle pc=RESET_PC, upd_cnt=0, no pc_upd pulse, state IDLE.
